tc_add_wb_collect: RTL
======================

# tc_add_wb_collect

Result-side collector for the tensor-core add pipeline. It accepts the pipe's valid/ready result stream (result, fflags, control tags) and buffers it in a small FIFO. It issues register-file writeback requests on a second valid/ready port and keeps per-warp sticky exception flags. It is the consumer of the add pipe's output handshake, and its `in_ready_o` drives the pipe's `out_ready_i`.

## Interface
Parameters:
- `EXPWIDTH`, default 5: exponent width of result.
- `PRECISION`, default 4: significand width; data width W = `EXPWIDTH+PRECISION`.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `WARP_NUM`, default `1<<`DEPTH_WARP``: number of warps with sticky flags.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, **synchronous, active-high**.
- `in_valid_i` in 1: result valid from the add pipe.
- `in_ready_o` out 1: collector can accept; connects to the pipe's `out_ready_i`.
- `result_i` in W: result value.
- `fflags_i` in 5: exception flags {NV,DZ,OF,UF,NX}.
- `ctrl_reg_idxw_i` in 8: destination register index.
- `ctrl_warpid_i` in `DEPTH_WARP`: warp id.
- `wb_valid_o` out 1: writeback request valid.
- `wb_ready_i` in 1: register file accepts the request.
- `wb_data_o` out W: data to write.
- `wb_reg_idxw_o` out 8: register index.
- `wb_warpid_o` out `DEPTH_WARP`: warp id.
- `flag_clr_i` in 1: clear the sticky flags of one warp.
- `flag_clr_warpid_i` in `DEPTH_WARP`: warp to clear.
- `flag_rd_warpid_i` in `DEPTH_WARP`: warp to read.
- `flag_rd_o` out 5: sticky flags of `flag_rd_warpid_i` (combinational read).
- `count_o` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Push:** `in_valid_i && in_ready_o`. Writes {result, reg_idxw, warpid} at the write pointer; the write pointer increments.
- **Pop:** `wb_valid_o && wb_ready_i`. The read pointer increments.
- **Pointers:** $clog2(DEPTH) bits, wrap modulo DEPTH. `count` is $clog2(DEPTH)+1 bits.
  - Count changes by +1 on push only, −1 on pop only, and is unchanged on simultaneous push and pop.
- `in_ready_o = (count != DEPTH)`. It is a function of registered count only; there is no combinational path from `wb_ready_i`. When full, no push occurs even if a pop happens in the same cycle.
- `wb_valid_o = (count != 0)`. `wb_*` outputs present the entry at the read pointer (first-word-fall-through).
  - While `wb_valid_o && !wb_ready_i`, the `wb_*` outputs are held stable.
- **Empty:** `wb_valid_o=0`. `wb_*` show the stale entry at the read pointer; the consumer ignores them.
- **Sticky flags:** array `sticky[WARP_NUM][5]`, updated on push as `sticky[warpid] |= fflags_i`, independent of writeback.
  - `flag_clr_i` sets `sticky[flag_clr_warpid_i] = 0`.
  - Clear and push to the same warp in the same cycle: the entry becomes `fflags_i` (clear first, then OR).
  - Clear and push to different warps in the same cycle: both updates apply.
- `flag_rd_o` reflects register state and does not bypass same-cycle updates.
- Ordering: results leave in acceptance order; no reordering.

## Timing
- Reset (`rst=1` at a rising edge) sets:
  - pointers, count, all sticky entries and all FIFO storage to 0;
  - therefore `in_ready_o=1`, `wb_valid_o=0`, `wb_data_o=0`, `wb_reg_idxw_o=0`, `wb_warpid_o=0`, `flag_rd_o=0`, `count_o=0`.
- Reset asserted mid-operation discards all buffered entries and flags at that edge. Pushes and pops in the reset cycle are ignored.
- Latency: push at edge N gives `wb_valid_o=1` after edge N; a request can be accepted in cycle N+1 (1 cycle).
- Throughput: 1 push and 1 pop per cycle sustained when not full/empty.
- Full boundary: with count=DEPTH, `in_ready_o=0` for the whole cycle. A pop at edge N gives `in_ready_o=1` in cycle N+1.
- Empty boundary: a push into an empty FIFO cannot be popped in the same cycle; there is no flow-through.

## Structure
- Shared package/header:
  - `DEPTH_WARP` (existing `define.v`);
  - fflags bit positions: NV=4, DZ=3, OF=2, UF=1, NX=0;
  - writeback payload width constant 8+`DEPTH_WARP`+W.
- Sub-module `tc_sync_fifo`: a generic parameterized FIFO (WIDTH, DEPTH) with the push/pop/count rules above.
- The top level instantiates it with the packed {data, idx, warpid} payload and holds the sticky-flag array and its clear logic.

## Test plan
- **Reset then single push:** push result=0x1A5, idx=7, warp=2, fflags=0x01 → next cycle `wb_valid_o=1`, `wb_data_o=0x1A5`, `wb_reg_idxw_o=7`, `wb_warpid_o=2`; `flag_rd_o` of warp 2 = 0x01.
- **Fill with `wb_ready_i=0`:** after 4 pushes, `count_o=4` and `in_ready_o=0`. A 5th `in_valid_i` is not accepted. Raising `wb_ready_i` for 1 cycle gives `in_ready_o=1` the next cycle.
- **Stall hold:** with `wb_valid_o=1`, `wb_ready_i=0` for 5 cycles → the `wb_*` outputs stay constant. Values come out in order 0x001, 0x002, 0x003.
- **Streaming:** continuous push and pop of 20 entries with `wb_ready_i=1` → count stays ≤1 and all 20 come out in order. Pointer wrap at DEPTH is exercised.
- **Flag clear collision:** warp 1 sticky=0x10, push warp 1 fflags=0x04 with `flag_clr_i` on warp 1 in the same cycle → `flag_rd_o=0x04`.
  - Same test with the clear on warp 3: warp 1 gives 0x14 and warp 3 gives 0.
- **Mid-operation reset:** 3 entries buffered, assert `rst` → next cycle `count_o=0`, `wb_valid_o=0`, `in_ready_o=1`, all flags 0.

Source files
------------

// File: rtl/tc_add_wb_collect_pkg.sv
// rtl/tc_add_wb_collect_pkg.sv - shared constants for the add-pipe writeback collector
package tc_add_wb_collect_pkg;

    // Warp id width, as used throughout the tensor core.
    localparam int DEPTH_WARP = 2;

    // Exception flag bit positions inside fflags {NV,DZ,OF,UF,NX}.
    localparam int FFLAGS_W  = 5;
    localparam int FFLAG_NV  = 4;
    localparam int FFLAG_DZ  = 3;
    localparam int FFLAG_OF  = 2;
    localparam int FFLAG_UF  = 1;
    localparam int FFLAG_NX  = 0;

    localparam int REG_IDX_W = 8;

    // Writeback payload {data, reg_idxw, warpid} width for a W-bit result.
    function automatic int wb_payload_w(input int w);
        return REG_IDX_W + DEPTH_WARP + w;
    endfunction

    // Payload width for the default 5-bit exponent, 4-bit significand result.
    localparam int WB_PAYLOAD_W = REG_IDX_W + DEPTH_WARP + 9;

endpackage

// File: rtl/tc_add_wb_collect_if.sv
// rtl/tc_add_wb_collect_if.sv - result stream, writeback and flag access bundle
interface tc_add_wb_collect_if
    import tc_add_wb_collect_pkg::*;
#(
    parameter int W     = 9,
    parameter int CNT_W = 3
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [W-1:0]           result_i;
    logic [FFLAGS_W-1:0]    fflags_i;
    logic [REG_IDX_W-1:0]   ctrl_reg_idxw_i;
    logic [DEPTH_WARP-1:0]  ctrl_warpid_i;

    logic                   wb_valid_o;
    logic                   wb_ready_i;
    logic [W-1:0]           wb_data_o;
    logic [REG_IDX_W-1:0]   wb_reg_idxw_o;
    logic [DEPTH_WARP-1:0]  wb_warpid_o;

    logic                   flag_clr_i;
    logic [DEPTH_WARP-1:0]  flag_clr_warpid_i;
    logic [DEPTH_WARP-1:0]  flag_rd_warpid_i;
    logic [FFLAGS_W-1:0]    flag_rd_o;
    logic [CNT_W-1:0]       count_o;

    // Environment side: add pipe, register file and flag CSR logic.
    modport master (
        output in_valid_i, result_i, fflags_i, ctrl_reg_idxw_i, ctrl_warpid_i,
        input  in_ready_o,
        input  wb_valid_o, wb_data_o, wb_reg_idxw_o, wb_warpid_o,
        output wb_ready_i,
        output flag_clr_i, flag_clr_warpid_i, flag_rd_warpid_i,
        input  flag_rd_o, count_o
    );

    // Collector side.
    modport slave (
        input  in_valid_i, result_i, fflags_i, ctrl_reg_idxw_i, ctrl_warpid_i,
        output in_ready_o,
        output wb_valid_o, wb_data_o, wb_reg_idxw_o, wb_warpid_o,
        input  wb_ready_i,
        input  flag_clr_i, flag_clr_warpid_i, flag_rd_warpid_i,
        output flag_rd_o, count_o
    );

endinterface

// File: rtl/tc_sync_fifo.sv
// rtl/tc_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module tc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [WIDTH-1:0]         m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Ready depends on registered occupancy only, so no path from m_tready.
    assign s_tready = (count != CNT_FULL);
    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr];
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    // Pointers, occupancy and storage; storage is cleared so outputs read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_tdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tc_add_wb_collect.sv
// rtl/tc_add_wb_collect.sv - buffers add-pipe results into writeback requests, keeps sticky flags
module tc_add_wb_collect
    import tc_add_wb_collect_pkg::*;
#(
    parameter int EXPWIDTH  = 5,
    parameter int PRECISION = 4,
    parameter int DEPTH     = 4,
    parameter int WARP_NUM  = 1 << DEPTH_WARP
) (
    input  logic                clk,
    input  logic                rst,
    tc_add_wb_collect_if.slave  bus
);
    localparam int W     = EXPWIDTH + PRECISION;
    localparam int PAY_W = wb_payload_w(W);

    logic [PAY_W-1:0]    fifo_in;
    logic [PAY_W-1:0]    fifo_out;
    logic                push;
    logic [FFLAGS_W-1:0] sticky     [WARP_NUM];
    logic [FFLAGS_W-1:0] sticky_nxt [WARP_NUM];

    assign fifo_in = {bus.result_i, bus.ctrl_reg_idxw_i, bus.ctrl_warpid_i};
    assign {bus.wb_data_o, bus.wb_reg_idxw_o, bus.wb_warpid_o} = fifo_out;
    assign push    = bus.in_valid_i && bus.in_ready_o;

    tc_sync_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (fifo_in),
        .s_tvalid (bus.in_valid_i),
        .s_tready (bus.in_ready_o),
        .m_tdata  (fifo_out),
        .m_tvalid (bus.wb_valid_o),
        .m_tready (bus.wb_ready_i),
        .count    (bus.count_o)
    );

    // Next sticky state: a clear applies before the OR of an accepted result's flags.
    always_comb begin
        for (int w = 0; w < WARP_NUM; w++) begin
            sticky_nxt[w] = sticky[w];
            if (bus.flag_clr_i && (bus.flag_clr_warpid_i == DEPTH_WARP'(w))) begin
                sticky_nxt[w] = '0;
            end
            if (push && (bus.ctrl_warpid_i == DEPTH_WARP'(w))) begin
                sticky_nxt[w] = sticky_nxt[w] | bus.fflags_i;
            end
        end
    end

    // Sticky flag registers.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WARP_NUM; w++) begin
            if (rst) begin
                sticky[w] <= '0;
            end else begin
                sticky[w] <= sticky_nxt[w];
            end
        end
    end

    assign bus.flag_rd_o = sticky[bus.flag_rd_warpid_i];

endmodule
